// File: rtl/address_register_bank.sv
// Purpose: NREGS x WIDTH address register bank (0=PC, 1=SP, 2..=AR) with two registered read ports.
// Latency: writes and reads both land one Clock edge later; read ports show pre-update contents.
// Backpressure: none; every edge with an enabled register and non-hold FunSel performs the operation.
//
// Ports:
//   Clock, Reset          - rising-edge clock, asynchronous active-low reset
//   I                     - load data (full and half-word loads)
//   RegSel, FunSel        - per-register enable mask, shared 3-bit function select
//   OutCSel/OutDSel       - read selects (values >= NREGS read register NREGS-1)
//   FlagClr               - synchronous clear of the sticky stack flags
//   OutC, OutD            - registered read ports
//   StackOvf, StackUnf    - sticky stack fault flags
// Optional feature: define ARF_STACK_BOUNDS_EN to enable SP bounds protection
// (SP_LOW/SP_HIGH); without it SP wraps freely and the flags read 0.
module address_register_bank #(
  parameter int               WIDTH    = 16,
  parameter int               NREGS    = 4,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(16'hFFFF),
  parameter logic [WIDTH-1:0] SP_LOW   = '0,
  parameter logic [WIDTH-1:0] SP_HIGH  = '1,
  localparam int              SELW     = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREGS-1:0] RegSel,
  input  logic [2:0]       FunSel,
  input  logic [SELW-1:0]  OutCSel,
  input  logic [SELW-1:0]  OutDSel,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             StackOvf,
  output logic             StackUnf
);

  localparam int SP_IDX = 1;
  localparam int HW     = WIDTH / 2;

  localparam logic [2:0] FN_DEC  = 3'b000;
  localparam logic [2:0] FN_INC  = 3'b001;
  localparam logic [2:0] FN_LD   = 3'b010;
  localparam logic [2:0] FN_CLR  = 3'b011;
  localparam logic [2:0] FN_LDLO = 3'b100;
  localparam logic [2:0] FN_LDHI = 3'b101;
  localparam logic [2:0] FN_INC2 = 3'b110;

  logic [WIDTH-1:0] regs    [NREGS];
  logic [WIDTH-1:0] nxt     [NREGS];
  logic [WIDTH-1:0] rd_view [2**SELW];
  logic             sp_ovf;
  logic             sp_unf;

  function automatic logic [WIDTH-1:0] apply_fun(
    input logic [WIDTH-1:0] cur,
    input logic [2:0]       fs,
    input logic [WIDTH-1:0] clr_val,
    input logic [WIDTH-1:0] din
  );
    case (fs)
      FN_DEC:  return cur - WIDTH'(1);
      FN_INC:  return cur + WIDTH'(1);
      FN_LD:   return din;
      FN_CLR:  return clr_val;
      FN_LDLO: return {cur[WIDTH-1:HW], din[HW-1:0]};
      FN_LDHI: return {din[HW-1:0], cur[HW-1:0]};
      FN_INC2: return cur + WIDTH'(2);
      default: return cur;
    endcase
  endfunction

  // Select values past the last register alias onto register NREGS-1.
  always_comb begin
    for (int i = 0; i < 2**SELW; i++) begin
      rd_view[i] = (i < NREGS) ? regs[i] : regs[NREGS-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      nxt[k] = RegSel[k] ? apply_fun(regs[k], FunSel, (k == SP_IDX) ? SP_RESET : '0, I)
                         : regs[k];
    end
    sp_ovf = 1'b0;
    sp_unf = 1'b0;
`ifdef ARF_STACK_BOUNDS_EN
    // Wrap on dec/inc is detected from the pre-update SP; the candidate
    // result is then range-checked. Clear and hold are never checked.
    if (RegSel[SP_IDX]) begin
      case (FunSel)
        FN_DEC:  sp_ovf = (regs[SP_IDX] == '0) || (nxt[SP_IDX] < SP_LOW);
        FN_INC:  sp_unf = (regs[SP_IDX] == '1) || (nxt[SP_IDX] > SP_HIGH);
        FN_INC2: sp_unf = (regs[SP_IDX][WIDTH-1:1] == '1) || (nxt[SP_IDX] > SP_HIGH);
        FN_LD, FN_LDLO, FN_LDHI: begin
          sp_ovf = nxt[SP_IDX] < SP_LOW;
          sp_unf = nxt[SP_IDX] > SP_HIGH;
        end
        default: ;
      endcase
      if (sp_ovf || sp_unf) nxt[SP_IDX] = regs[SP_IDX];
    end
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= (k == SP_IDX) ? SP_RESET : '0;
      end
      OutC <= '0;
      OutD <= '0;
    end else begin
      regs <= nxt;
      OutC <= rd_view[OutCSel];
      OutD <= rd_view[OutDSel];
    end
  end

`ifdef ARF_STACK_BOUNDS_EN
  // A new violation takes priority over a same-edge FlagClr.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      StackOvf <= 1'b0;
      StackUnf <= 1'b0;
    end else begin
      StackOvf <= sp_ovf | (StackOvf & ~FlagClr);
      StackUnf <= sp_unf | (StackUnf & ~FlagClr);
    end
  end
`else
  assign StackOvf = 1'b0;
  assign StackUnf = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{FlagClr, SP_LOW, SP_HIGH, sp_ovf, sp_unf};
`endif

endmodule

// File: doc/address_register_bank.md
# address_register_bank

Parametrised address register bank: NREGS registers of WIDTH bits (index 0 = PC, 1 = SP, 2..NREGS-1 = AR0..), each with its own enable and a shared 3-bit function select. It provides two registered read ports (OutC, OutD) that feed the memory-address and ALU-operand paths. It extends the fixed 3×16-bit bank with:
- half-word loads
- increment-by-two
- a programmable SP reset value
- optional stack-bounds protection with sticky fault flags

## Interface
- WIDTH, 16, register width; must be even and ≥ 8
- NREGS, 4, number of registers; ≥ 3
- SELW, $clog2(NREGS), read-select width (derived, not overridden)
- SP_RESET, 16'hFFFF (truncated to WIDTH), SP value on reset and on the clear function
- SP_LOW, 0, lowest legal SP (bounds build only)
- SP_HIGH, all ones, highest legal SP (bounds build only)

- Clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-low reset
- I  in  WIDTH  load data
- RegSel  in  NREGS  per-register enable mask; bit k enables register k; any number of bits may be set
- FunSel  in  3  function applied to every enabled register
- OutCSel  in  SELW  read-select for OutC
- OutDSel  in  SELW  read-select for OutD
- FlagClr  in  1  clears the sticky stack flags
- OutC  out  WIDTH  registered read port C
- OutD  out  WIDTH  registered read port D
- StackOvf  out  1  sticky flag: SP decrement or load below SP_LOW
- StackUnf  out  1  sticky flag: SP increment or load above SP_HIGH

## Operation
FunSel encoding, applied per enabled register; disabled registers hold:
- 000: decrement by 1
- 001: increment by 1
- 010: load I
- 011: clear (SP loads SP_RESET; all other registers load 0)
- 100: load low half (reg[WIDTH/2-1:0] ← I[WIDTH/2-1:0]; upper half held)
- 101: load high half (reg[WIDTH-1:WIDTH/2] ← I[WIDTH/2-1:0]; lower half held)
- 110: increment by 2
- 111: hold

Arithmetic and read rules:
- All arithmetic is modulo 2^WIDTH (wrap-around); no carry is exported.
- Read select values ≥ NREGS map to register NREGS-1.
- OutC and OutD capture the selected register's value from *before* the current edge's update.
- Both ports may select the same register.

Reset (Reset low, asynchronous):
- All registers 0, except SP = SP_RESET.
- OutC = 0, OutD = 0.
- StackOvf = 0, StackUnf = 0.
- A reset asserted mid-sequence discards any pending update.

## Timing
- Write latency: 1 cycle. A value written at edge n is visible on OutC/OutD after edge n+1, provided the select is held.
- Read latency: 1 cycle from select change to output.
- No handshake: every edge with a non-hold FunSel and a set enable bit performs the operation.
- Flags update on the same edge as the offending SP operation.
- FlagClr is synchronous. If FlagClr and a new violation occur on the same edge, the set wins.

## Configuration
Macro: ARF_STACK_BOUNDS_EN.

When defined (applies when SP is enabled):
- The candidate SP result is computed with wrap detection.
- The update is suppressed and SP holds if the operation is a decrement, load or half-load whose result is < SP_LOW, or a decrement that wraps. StackOvf is set.
- The update is suppressed and SP holds if the operation is an increment (+1/+2), load or half-load whose result is > SP_HIGH, or an increment that wraps. StackUnf is set.
- Clear (FunSel 011) is never checked.
- Other registers are unaffected.

When undefined:
- SP updates unconditionally with plain wrap-around.
- StackOvf and StackUnf are tied to 0.
- FlagClr is ignored.
- SP_LOW and SP_HIGH are unused.

## Test plan
- **Reset:** Reset low with WIDTH=16, NREGS=4 → OutC = OutD = 0, flags 0. Then OutCSel=1 for one edge → OutC = 16'hFFFF.
- **Load/read ordering:** RegSel=4'b0001, FunSel=010, I=16'h1234, OutCSel=0 → OutC shows the old PC (0) on the first edge and 16'h1234 on the second.
- **Half-loads and wrap:** load AR0 = 16'hFFFF, then FunSel=110 → AR0 = 16'h0001. FunSel=100 with I=16'h00AB → AR0 = 16'h00AB. FunSel=101 with I=16'h0012 → AR0 = 16'h12AB.
- **Multi-enable and select clamp:** RegSel=4'b1111, FunSel=011 → PC, AR0, AR1 = 0 and SP = 16'hFFFF. Then OutDSel=3 vs the clamp mapping, exercised with NREGS=3 and OutDSel=3 → reads register 2.
- **Bounds (ARF_STACK_BOUNDS_EN, SP_LOW=16'hFF00):**
  - SP=16'hFF00, FunSel=000 → SP holds at FF00, StackOvf=1.
  - FlagClr together with another decrement → StackOvf stays 1.
  - FlagClr alone → StackOvf=0.
  - Same stimulus without the macro → SP = 16'hFEFF, flags 0.
- **Async reset mid-operation:** assert Reset between edges during an SP increment sequence → SP = SP_RESET and flags 0 immediately, before the next edge; the first edge after release performs no stale update.
